mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port RAM controller (`mem_cmd`/`mem_addr`/`write_data`/`read_data`, 9-bit address, 16-bit data) between the CPU (requester 0) and the debug/load port (requester 1). It accepts one access at a time, drives the RAM command bus for exactly two cycles, captures read data and returns a one-cycle acknowledge to the winning requester. It sits between the CPU/loader and the RAM controller and is the only driver of the RAM command bus.

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port RAM controller.
// Round-robin by default; `MEM_ARB_FIXED_PRIORITY_EN makes r0 always win a tie.
module mem_arbiter #(
  parameter int AW        = 9,
  parameter int DW        = 16,
  parameter int RAM_WORDS = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic [1:0]    r0_cmd,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r1_req,
  input  logic [1:0]    r1_cmd,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r0_ack,
  output logic          r0_err,
  output logic [DW-1:0] r0_rdata,
  output logic          r1_ack,
  output logic          r1_err,
  output logic [DW-1:0] r1_rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] MNONE = 2'b00;
  localparam logic [1:0] MREAD = 2'b01;
  localparam logic [AW:0] LIM  = RAM_WORDS[AW:0];
  logic [1:0]    state_q, state_d;
  logic          win_q, win_d, err_q, err_d;
  logic [1:0]    mem_cmd_q, mem_cmd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]    ack_q, ack_d, rerr_q, rerr_d;
  logic [DW-1:0] r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
  logic          win, grant, sel_err;
  logic [1:0]    sel_cmd;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
  assign win = r1_req & ~r0_req;
`else
  logic last_grant_q, last_grant_d;
  // r1 takes a tie only when r0 was granted last
  assign win          = r1_req & (~r0_req | ~last_grant_q);
  assign last_grant_d = grant ? win : last_grant_q;
  always_ff @(posedge clk) last_grant_q <= reset ? 1'b1 : last_grant_d;
`endif
  always_comb begin
    grant       = (state_q != ISSUE) && (state_q != HOLD) && (r0_req || r1_req);
    sel_cmd     = win ? r1_cmd : r0_cmd;
    sel_addr    = win ? r1_addr : r0_addr;
    sel_wdata   = win ? r1_wdata : r0_wdata;
    sel_err     = (sel_cmd == MNONE) || (sel_cmd == 2'b11) || ({1'b0, sel_addr} >= LIM);
    state_d     = IDLE;
    win_d       = win_q;
    err_d       = err_q;
    mem_cmd_d   = mem_cmd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack_d       = 2'b00;
    rerr_d      = 2'b00;
    r0_rdata_d  = r0_rdata_q;
    r1_rdata_d  = r1_rdata_q;
    if (state_q == ISSUE) begin
      state_d = HOLD;
    end else if (state_q == HOLD) begin
      mem_cmd_d  = MNONE;
      ack_d      = win_q ? 2'b10 : 2'b01;
      rerr_d     = err_q ? ack_d : 2'b00;
      // errored accesses never drive MREAD, so this is a legal read
      r0_rdata_d = (mem_cmd_q == MREAD && !win_q) ? mem_rdata : r0_rdata_q;
      r1_rdata_d = (mem_cmd_q == MREAD && win_q) ? mem_rdata : r1_rdata_q;
    end else if (grant) begin
      state_d     = ISSUE;
      win_d       = win;
      err_d       = sel_err;
      mem_cmd_d   = sel_err ? MNONE : sel_cmd;
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      err_q       <= 1'b0;
      mem_cmd_q   <= MNONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= 2'b00;
      rerr_q      <= 2'b00;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      err_q       <= err_d;
      mem_cmd_q   <= mem_cmd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      rerr_q      <= rerr_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
    end
  end
  assign r0_ack    = ack_q[0];
  assign r1_ack    = ack_q[1];
  assign r0_err    = rerr_q[0];
  assign r1_err    = rerr_q[1];
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
  assign mem_cmd   = mem_cmd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small behavioural RAM.
module tb_mem_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic r0_req = 0, r1_req = 0;
  logic [1:0] r0_cmd = 0, r1_cmd = 0;
  logic [8:0] r0_addr = 0, r1_addr = 0;
  logic [15:0] r0_wdata = 0, r1_wdata = 0;
  logic r0_ack, r0_err, r1_ack, r1_err;
  logic [15:0] r0_rdata, r1_rdata, mem_wdata;
  logic [1:0] mem_cmd;
  logic [8:0] mem_addr;
  wire  [15:0] mem_rdata;
  logic [15:0] ram [256];
  logic [15:0] rd_q = 0;
  logic rd_v = 0;
  int n_run = 0, n_fail = 0;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_cmd(r0_cmd), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_cmd(r1_cmd), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  // RAM model: acts on the command present at each edge, read data floats otherwise
  always @(posedge clk) begin
    if (mem_cmd == 2'b10) ram[mem_addr[7:0]] <= mem_wdata;
    rd_v <= (mem_cmd == 2'b01);
    rd_q <= ram[mem_addr[7:0]];
  end
  assign mem_rdata = rd_v ? rd_q : 16'hzzzz;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run1(input string tag, input bit p, input logic [1:0] c,
                      input logic [8:0] a, input logic [15:0] d, input bit e);
    logic [1:0] mc;
    mc = e ? 2'b00 : c;
    if (p) begin
      r1_req = 1; r1_cmd = c; r1_addr = a; r1_wdata = d;
    end else begin
      r0_req = 1; r0_cmd = c; r0_addr = a; r0_wdata = d;
    end
    tick;
    chk({tag, "_cmd_issue"}, 32'(mem_cmd), 32'(mc));
    chk({tag, "_addr_issue"}, 32'(mem_addr), 32'(a));
    tick;
    chk({tag, "_cmd_hold"}, 32'(mem_cmd), 32'(mc));
    chk({tag, "_ack_early"}, 32'({r1_ack, r0_ack}), 0);
    tick;
    chk({tag, "_cmd_ack"}, 32'(mem_cmd), 0);
    chk({tag, "_ack"}, 32'({r1_ack, r0_ack}), p ? 32'd2 : 32'd1);
    chk({tag, "_err"}, 32'({r1_err, r0_err}), e ? (p ? 32'd2 : 32'd1) : 32'd0);
    r0_req = 0;
    r1_req = 0;
    tick;
    chk({tag, "_ack_drop"}, 32'({r1_ack, r0_ack}), 0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'(i);
    ram[0] = 16'hA0A0;
    ram[5] = 16'h5555;
    ram[255] = 16'hB1B1;
    tick;
    tick;
    reset = 0;
    chk("rst_cmd", 32'(mem_cmd), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_ack", 32'({r1_ack, r0_ack, r1_err, r0_err}), 0);
    chk("rst_rdata", {r1_rdata, r0_rdata}, 0);
    run1("wr1", 0, 2'b10, 9'd1, 16'h0F0F, 0);
    chk("wr1_ram", 32'(ram[1]), 32'h0F0F);
    run1("rd1", 0, 2'b01, 9'd1, 16'h0000, 0);
    chk("rd1_rdata", 32'(r0_rdata), 32'h0F0F);
    // round-robin after reset: r0 takes the first tie
    reset = 1;
    tick;
    reset = 0;
    r0_req = 1; r0_cmd = 2'b01; r0_addr = 9'd0;
    r1_req = 1; r1_cmd = 2'b01; r1_addr = 9'd255;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rr_addr", 32'(mem_addr), (!FIXED && i % 2 == 1) ? 32'd255 : 32'd0);
      tick;
      tick;
      chk("rr_ack", 32'({r1_ack, r0_ack}), (!FIXED && i % 2 == 1) ? 32'd2 : 32'd1);
    end
    r0_req = 0;
    r1_req = 0;
    tick;
    chk("rr_r0_rdata", 32'(r0_rdata), 32'hA0A0);
    chk("rr_r1_rdata", 32'(r1_rdata), FIXED ? 32'h0 : 32'hB1B1);
    run1("oor", 1, 2'b01, 9'h100, 16'h0000, 1);
    chk("oor_rdata", 32'(r1_rdata), FIXED ? 32'h0 : 32'hB1B1);
    run1("cmd11", 0, 2'b11, 9'd5, 16'hDEAD, 1);
    run1("cmd00", 0, 2'b00, 9'd5, 16'hBEEF, 1);
    run1("rd5", 0, 2'b01, 9'd5, 16'h0000, 0);
    chk("rd5_rdata", 32'(r0_rdata), 32'h5555);
    // reset during HOLD of an r1 write abandons it without ack
    r1_req = 1; r1_cmd = 2'b10; r1_addr = 9'd7; r1_wdata = 16'h7777;
    tick;
    tick;
    chk("rsth_cmd_hold", 32'(mem_cmd), 32'd2);
    reset = 1;
    tick;
    reset = 0;
    chk("rsth_cmd", 32'(mem_cmd), 0);
    chk("rsth_addr", 32'(mem_addr), 0);
    chk("rsth_ack", 32'({r1_ack, r0_ack}), 0);
    tick;
    chk("rsth_noack", 32'({r1_ack, r0_ack}), 0);
    r1_req = 0;
    tick;
    tick;
    run1("rewr", 1, 2'b10, 9'd7, 16'h7777, 0);
    chk("rewr_ram", 32'(ram[7]), 32'h7777);
    // r0 holds req through its ack: accesses run back to back every 3 cycles
    r0_req = 1; r0_cmd = 2'b01; r0_addr = 9'd1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("b2b_ack", 32'(r0_ack), (i % 3 == 2) ? 32'd1 : 32'd0);
    end
    r0_req = 0;
    chk("b2b_rdata", 32'(r0_rdata), 32'h0F0F);
    for (int i = 0; i < 5; i++) tick;
    chk("idle_rdata0", 32'(r0_rdata), 32'h0F0F);
    chk("idle_rdata1", 32'(r1_rdata), 0);
    chk("idle_cmd", 32'(mem_cmd), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
